shot_detect: RTL and testbench



---
 rtl/accel_pkg.sv | 23 ++
 rtl/movavg_filter.sv | 79 +++++++
 rtl/shot_detect.sv | 133 +++++++++++++
 tb/tb_shot_detect.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: types and default constants shared by the accelerometer
// shot-detection path (moving-average filter and gesture FSM).
package accel_pkg;

    // Width of one accelerometer sample as delivered by the SPI master.
    localparam int SAMPLE_W = 16;

    // Gesture FSM states. The encoding is visible on state_dbg.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WINDUP   = 2'd1,
        RELEASE  = 2'd2,
        COOLDOWN = 2'd3
    } shot_state_t;

    // Default filter window and gesture thresholds.
    localparam int                          AVG_LOG2_DEF         = 2;
    localparam logic signed [SAMPLE_W-1:0] BACK_THR_DEF         = -16'sd400;
    localparam logic signed [SAMPLE_W-1:0] FWD_THR_DEF          = 16'sd600;
    localparam int                          WIN_SAMPLES_DEF      = 64;
    localparam int                          COOLDOWN_SAMPLES_DEF = 128;

endpackage

// File: rtl/movavg_filter.sv
// movavg_filter: moving average over the last 2^AVG_LOG2 samples, kept as a
// running sum so each new sample costs one add and one subtract. The output
// is floored (arithmetic shift) and held between strobes; the strobe stays
// low until the window has been filled once since reset.
module movavg_filter
    import accel_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic                       iclk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] x_raw,
    input  logic                       x_valid,
    output logic signed [SAMPLE_W-1:0] x_filt,
    output logic                       filt_valid
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = SAMPLE_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    // buf_q[0] is the newest sample, buf_q[DEPTH-1] the oldest.
    logic signed [SAMPLE_W-1:0] buf_q [DEPTH];
    logic signed [SUM_W-1:0]    sum_q, sum_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic signed [SAMPLE_W-1:0] x_filt_q, x_filt_d;
    logic                       filt_valid_q, filt_valid_d;

    // Next running sum, fill level and filtered output for an incoming sample.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sum_d        = sum_q;
        fill_d       = fill_q;
        x_filt_d     = x_filt_q;
        filt_valid_d = 1'b0;
        if (x_valid) begin
            sum_d    = sum_q + SUM_W'(x_raw) - SUM_W'(buf_q[DEPTH-1]);
            x_filt_d = SAMPLE_W'(sum_d >>> AVG_LOG2);
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
            // This sample completes (or extends) a full window.
            filt_valid_d = (fill_q >= FILL_W'(DEPTH - 1));
        end
    end

    // Sample buffer, running sum, fill counter and output registers.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is cleared together with the sum, because the
            // running sum is only correct while it equals the buffer total.
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            sum_q        <= '0;
            fill_q       <= '0;
            x_filt_q     <= '0;
            filt_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the shift read the old
            // contents of every slot, regardless of statement order.
            if (x_valid) begin
                buf_q[0] <= x_raw;
                for (int i = 1; i < DEPTH; i++) begin
                    buf_q[i] <= buf_q[i-1];
                end
            end
            sum_q        <= sum_d;
            fill_q       <= fill_d;
            x_filt_q     <= x_filt_d;
            filt_valid_q <= filt_valid_d;
        end
    end

    assign x_filt     = x_filt_q;
    assign filt_valid = filt_valid_q;

endmodule

// File: rtl/shot_detect.sv
// shot_detect: recognises a basketball shot in the filtered X-axis stream.
// A wind-up (filtered X at or below BACK_THR) followed within WIN_SAMPLES
// filtered samples by a release (at or above FWD_THR) produces a one-cycle
// shot_valid carrying the peak release value. A cooldown then ignores
// COOLDOWN_SAMPLES filtered samples. The FSM only moves on filt_valid.
module shot_detect
    import accel_pkg::*;
#(
    parameter int                          AVG_LOG2         = AVG_LOG2_DEF,
    parameter logic signed [SAMPLE_W-1:0] BACK_THR         = BACK_THR_DEF,
    parameter logic signed [SAMPLE_W-1:0] FWD_THR          = FWD_THR_DEF,
    parameter int                          WIN_SAMPLES      = WIN_SAMPLES_DEF,
    parameter int                          COOLDOWN_SAMPLES = COOLDOWN_SAMPLES_DEF
) (
    input  logic                       iclk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] x_raw,
    input  logic                       x_valid,
    output logic signed [SAMPLE_W-1:0] x_filt,
    output logic                       filt_valid,
    output logic                       shot_valid,
    output logic signed [SAMPLE_W-1:0] shot_peak,
    output logic [1:0]                 state_dbg,
    output logic                       busy
);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int CNT_LIMIT = (WIN_SAMPLES > COOLDOWN_SAMPLES) ? WIN_SAMPLES
                                                                 : COOLDOWN_SAMPLES;
    localparam int CNT_W = $clog2(CNT_LIMIT);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_SAMPLES - 1);

    shot_state_t                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] peak_q, peak_d;
    logic signed [SAMPLE_W-1:0] rel_peak;
    logic                       shot_valid_q, shot_valid_d;
    logic signed [SAMPLE_W-1:0] shot_peak_q, shot_peak_d;

    movavg_filter #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_filter (
        .iclk       (iclk),
        .rst        (rst),
        .x_raw      (x_raw),
        .x_valid    (x_valid),
        .x_filt     (x_filt),
        .filt_valid (filt_valid)
    );

    // State register plus the counter, running peak and shot outputs.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            peak_q       <= '0;
            shot_valid_q <= 1'b0;
            shot_peak_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            peak_q       <= peak_d;
            shot_valid_q <= shot_valid_d;
            shot_peak_q  <= shot_peak_d;
        end
    end

    // Next-state logic: one transition per filtered sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        peak_d       = peak_q;
        shot_valid_d = 1'b0;
        rel_peak     = (x_filt > peak_q) ? x_filt : peak_q;
        if (filt_valid) begin
            case (state_q)
                IDLE: begin
                    if (x_filt <= BACK_THR) begin
                        state_d = WINDUP;
                        cnt_d   = '0;
                    end
                end
                WINDUP: begin
                    if (x_filt >= FWD_THR) begin
                        state_d = RELEASE;
                        peak_d  = x_filt;
                        cnt_d   = '0;
                    end else if (cnt_q == WIN_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    peak_d = rel_peak;
                    // Release ends when X drops back or the window runs out;
                    // either way the shot is reported with the peak so far.
                    if ((x_filt < FWD_THR) || (cnt_q == WIN_LAST)) begin
                        shot_valid_d = 1'b1;
                        state_d      = COOLDOWN;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == CD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        shot_peak_d = shot_valid_d ? rel_peak : shot_peak_q;
    end

    // Output logic: everything comes straight from registers.
    always_comb begin
        state_dbg  = state_q;
        busy       = (state_q != IDLE);
        shot_valid = shot_valid_q;
        shot_peak  = shot_peak_q;
    end

endmodule

// File: tb/tb_shot_detect.sv
// tb_shot_detect: directed scenarios for the filter and gesture FSM, plus
// randomized streams (spaced and back-to-back) checked against a behavioural
// model that averages a sample history and tracks the gesture phase.
`timescale 1ns/1ps
module tb_shot_detect;

    logic               iclk = 1'b0;
    logic               rst;
    logic signed [15:0] x_raw;
    logic               x_valid;
    logic signed [15:0] x_filt;
    logic               filt_valid;
    logic               shot_valid;
    logic signed [15:0] shot_peak;
    logic [1:0]         state_dbg;
    logic               busy;

    shot_detect dut (
        .iclk       (iclk),
        .rst        (rst),
        .x_raw      (x_raw),
        .x_valid    (x_valid),
        .x_filt     (x_filt),
        .filt_valid (filt_valid),
        .shot_valid (shot_valid),
        .shot_peak  (shot_peak),
        .state_dbg  (state_dbg),
        .busy       (busy)
    );

    always #5 iclk = ~iclk;

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit fv;    // a filtered value is produced for this sample
        int f;     // filtered value
        bit shot;  // this sample ends a shot
        int pk;    // shot_peak after this sample
        int st;    // gesture phase after this sample (0..3)
    } exp_t;

    int m_hist[$];
    int m_count;
    int m_phase;      // 0 idle, 1 wind-up, 2 release, 3 cooldown
    int m_seen;       // filtered samples consumed in the current phase
    int m_run_peak;
    int m_held_peak;

    function automatic void model_reset();
        m_hist.delete();
        m_count     = 0;
        m_phase     = 0;
        m_seen      = 0;
        m_run_peak  = 0;
        m_held_peak = 0;
    endfunction

    function automatic exp_t model_push(input int x);
        exp_t e;
        int   sum;
        int   fl;
        e = '{default: 0};
        m_hist.push_front(x);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        m_count++;
        if (m_count >= 4) begin
            sum = 0;
            foreach (m_hist[i]) sum += m_hist[i];
            fl = sum / 4;
            if (sum < 0 && (sum % 4) != 0) fl = fl - 1;
            e.fv = 1;
            e.f  = fl;
            case (m_phase)
                0: if (fl <= -400) begin m_phase = 1; m_seen = 0; end
                1: begin
                    if (fl >= 600) begin
                        m_phase = 2; m_seen = 0; m_run_peak = fl;
                    end else begin
                        m_seen++;
                        if (m_seen == 64) m_phase = 0;
                    end
                end
                2: begin
                    if (fl > m_run_peak) m_run_peak = fl;
                    m_seen++;
                    if (fl < 600 || m_seen == 64) begin
                        e.shot = 1; m_held_peak = m_run_peak;
                        m_phase = 3; m_seen = 0;
                    end
                end
                default: begin
                    m_seen++;
                    if (m_seen == 128) begin m_phase = 0; m_seen = 0; end
                end
            endcase
        end
        e.pk = m_held_peak;
        e.st = m_phase;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    exp_t               last_exp;
    logic               obs_fv, obs_shot, obs_busy;
    logic signed [15:0] obs_f, obs_pk;
    logic [1:0]         obs_st;
    int                 stim_q[$];

    // One sample with idle cycles after it; captures filter outputs one cycle
    // after the strobe and FSM outputs one cycle later.
    task automatic send(input int x);
        @(negedge iclk);
        x_raw    = 16'(x);
        x_valid  = 1'b1;
        last_exp = model_push(x);
        @(negedge iclk);
        x_valid = 1'b0;
        obs_fv  = filt_valid;
        obs_f   = x_filt;
        @(negedge iclk);
        obs_shot = shot_valid;
        obs_pk   = shot_peak;
        obs_st   = state_dbg;
        obs_busy = busy;
    endtask

    task automatic build_stim(input int segs);
        int v, len, kind;
        logic [15:0] r16;
        stim_q.delete();
        for (int s = 0; s < segs; s++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    len = $urandom_range(4, 8);
                    for (int k = 0; k < len; k++) begin
                        v = $urandom_range(420, 1500); stim_q.push_back(-v);
                    end
                end
                1: begin
                    len = $urandom_range(2, 9);
                    for (int k = 0; k < len; k++) begin
                        v = $urandom_range(620, 3000); stim_q.push_back(v);
                    end
                end
                2: begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        v = $urandom_range(0, 400); stim_q.push_back(v - 200);
                    end
                end
                3: begin
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) begin
                        r16 = 16'($urandom); stim_q.push_back(int'($signed(r16)));
                    end
                end
                4: begin
                    len = $urandom_range(66, 72);
                    for (int k = 0; k < len; k++) stim_q.push_back(1500);
                end
                default: begin
                    len = $urandom_range(100, 135);
                    for (int k = 0; k < len; k++) stim_q.push_back(0);
                end
            endcase
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; x_valid = 1'b0; x_raw = '0;
        repeat (3) @(negedge iclk);
        checks++;
        if (x_filt !== 16'sd0 || filt_valid !== 1'b0 || shot_valid !== 1'b0 ||
            shot_peak !== 16'sd0 || state_dbg !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial got filt=%0d fv=%b shot=%b peak=%0d st=%0d busy=%b exp all 0",
                     x_filt, filt_valid, shot_valid, shot_peak, state_dbg, busy);
        end
        rst = 1'b0;
        model_reset();
        send(100); send(200); send(-300); send(5000); send(7);
        checks++;
        if (obs_f !== 16'sd1226) begin
            errors++; $display("FAIL reset_prefill got=%0d exp=1226", obs_f);
        end
        @(negedge iclk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (x_filt !== 16'sd0 || filt_valid !== 1'b0 || shot_valid !== 1'b0 ||
            shot_peak !== 16'sd0 || state_dbg !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got filt=%0d fv=%b shot=%b peak=%0d st=%0d busy=%b exp all 0",
                     x_filt, filt_valid, shot_valid, shot_peak, state_dbg, busy);
        end
        @(negedge iclk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_filter();
        int xs  [9] = '{100, 200, 300, 400, 800, -1, -1, -1, -2};
        int ef  [9] = '{0, 0, 0, 250, 425, 374, 299, 199, -2};
        for (int i = 0; i < 9; i++) begin
            send(xs[i]);
            checks++;
            if (obs_fv !== (i >= 3)) begin
                errors++; $display("FAIL filt_valid[%0d] got=%b exp=%b", i, obs_fv, (i >= 3));
            end
            if (i >= 3) begin
                checks++;
                if (obs_f !== 16'(ef[i])) begin
                    errors++; $display("FAIL filt_value[%0d] got=%0d exp=%0d", i, obs_f, ef[i]);
                end
            end
        end
    endtask

    task automatic test_valid_shot();
        int xs  [10] = '{-500, -500, -500, -500, 1000, 1000, 1000, 1000, 0, 0};
        int ef  [10] = '{-126, -251, -376, -500, -125, 250, 625, 1000, 750, 500};
        int est [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
        for (int i = 0; i < 10; i++) begin
            send(xs[i]);
            checks++;
            if (obs_f !== 16'(ef[i]) || obs_st !== 2'(est[i])) begin
                errors++;
                $display("FAIL shot_seq[%0d] got filt=%0d st=%0d exp filt=%0d st=%0d",
                         i, obs_f, obs_st, ef[i], est[i]);
            end
            checks++;
            if (obs_shot !== (i == 9)) begin
                errors++; $display("FAIL shot_pulse[%0d] got=%b exp=%b", i, obs_shot, (i == 9));
            end
        end
        checks++;
        if (obs_pk !== 16'sh03E8 || obs_busy !== 1'b1) begin
            errors++; $display("FAIL shot_peak got=%0d busy=%b exp=1000 busy=1", obs_pk, obs_busy);
        end
        @(negedge iclk);
        checks++;
        if (shot_valid !== 1'b0 || shot_peak !== 16'sd1000) begin
            errors++; $display("FAIL shot_single got shot=%b peak=%0d exp shot=0 peak=1000",
                               shot_valid, shot_peak);
        end
    endtask

    task automatic test_cooldown();
        int pat [10] = '{-500, -500, -500, -500, 1000, 1000, 1000, 1000, 0, 0};
        bit bad = 0;
        for (int k = 0; k < 50; k++) begin
            send(0);
            if (obs_shot !== 1'b0 || obs_st !== 2'd3) bad = 1;
        end
        for (int k = 0; k < 10; k++) begin
            send(pat[k]);
            if (obs_shot !== 1'b0 || obs_st !== 2'd3) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL cooldown_ignore got shot/state change exp st=3 no shot");
        end
        for (int k = 1; k <= 68; k++) begin
            send(0);
            checks++;
            if (obs_st !== ((k < 68) ? 2'd3 : 2'd0)) begin
                errors++; $display("FAIL cooldown_len[%0d] got=%0d exp=%0d", k, obs_st, (k < 68) ? 3 : 0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            send(pat[k]);
            checks++;
            if (obs_shot !== (k == 9)) begin
                errors++; $display("FAIL cooldown_after[%0d] got=%b exp=%b", k, obs_shot, (k == 9));
            end
        end
        checks++;
        if (obs_pk !== 16'sd1000) begin
            errors++; $display("FAIL cooldown_peak got=%0d exp=1000", obs_pk);
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 128; k++) send(0);
        checks++;
        if (obs_st !== 2'd0) begin
            errors++; $display("FAIL timeout_pre got=%0d exp=0", obs_st);
        end
        for (int k = 0; k < 4; k++) send(-500);
        checks++;
        if (obs_st !== 2'd1) begin
            errors++; $display("FAIL timeout_arm got=%0d exp=1", obs_st);
        end
        for (int k = 1; k <= 64; k++) begin
            send(0);
            checks++;
            if (obs_st !== ((k < 64) ? 2'd1 : 2'd0) || obs_shot !== 1'b0) begin
                errors++;
                $display("FAIL timeout[%0d] got st=%0d shot=%b exp st=%0d shot=0",
                         k, obs_st, obs_shot, (k < 64) ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset_release();
        for (int k = 0; k < 4; k++) send(-500);
        for (int k = 0; k < 3; k++) send(1000);
        checks++;
        if (obs_st !== 2'd2) begin
            errors++; $display("FAIL rr_release got=%0d exp=2", obs_st);
        end
        @(negedge iclk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (state_dbg !== 2'd0 || busy !== 1'b0 || shot_peak !== 16'sd0 ||
            shot_valid !== 1'b0 || filt_valid !== 1'b0 || x_filt !== 16'sd0) begin
            errors++;
            $display("FAIL rr_async got st=%0d busy=%b peak=%0d shot=%b fv=%b filt=%0d exp all 0",
                     state_dbg, busy, shot_peak, shot_valid, filt_valid, x_filt);
        end
        @(negedge iclk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            send(1000);
            checks++;
            if (obs_fv !== 1'b0 || obs_shot !== 1'b0) begin
                errors++; $display("FAIL rr_refill[%0d] got fv=%b shot=%b exp 0 0", k, obs_fv, obs_shot);
            end
        end
        send(0);
        checks++;
        if (obs_fv !== 1'b1 || obs_f !== 16'sd750 || obs_st !== 2'd0) begin
            errors++; $display("FAIL rr_first got fv=%b filt=%0d st=%0d exp 1 750 0", obs_fv, obs_f, obs_st);
        end
    endtask

    task automatic test_back_to_back();
        exp_t p1, p2;
        bit   prev_shot = 0;
        int   n;
        build_stim(30);
        n  = stim_q.size();
        p1 = '{default: 0};
        p2 = '{default: 0};
        for (int i = 0; i < n + 2; i++) begin
            @(negedge iclk);
            if (i >= 1) begin
                checks++;
                if (filt_valid !== p1.fv || (p1.fv && x_filt !== 16'(p1.f))) begin
                    errors++;
                    $display("FAIL b2b_filt[%0d] got fv=%b filt=%0d exp fv=%b filt=%0d",
                             i - 1, filt_valid, x_filt, p1.fv, p1.f);
                end
            end
            if (i >= 2) begin
                checks++;
                if (shot_valid !== p2.shot || shot_peak !== 16'(p2.pk) || state_dbg !== 2'(p2.st)) begin
                    errors++;
                    $display("FAIL b2b_fsm[%0d] got shot=%b peak=%0d st=%0d exp shot=%b peak=%0d st=%0d",
                             i - 2, shot_valid, shot_peak, state_dbg, p2.shot, p2.pk, p2.st);
                end
            end
            checks++;
            if (shot_valid === 1'b1 && prev_shot) begin
                errors++; $display("FAIL b2b_double_shot[%0d] got two high cycles exp one", i);
            end
            prev_shot = (shot_valid === 1'b1);
            p2 = p1;
            if (i < n) begin
                x_raw   = 16'(stim_q[i]);
                x_valid = 1'b1;
                p1      = model_push(stim_q[i]);
            end else begin
                x_valid = 1'b0;
                p1      = '{fv: 0, f: 0, shot: 0, pk: m_held_peak, st: m_phase};
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_random();
        build_stim(40);
        // Lead with a held release that must end on the window limit.
        for (int k = 0; k < 80; k++) stim_q.push_front((k < 76) ? 1500 : -900);
        for (int k = 0; k < 135; k++) stim_q.push_front(0);
        foreach (stim_q[i]) begin
            send(stim_q[i]);
            checks++;
            if (obs_fv !== last_exp.fv || (last_exp.fv && obs_f !== 16'(last_exp.f))) begin
                errors++;
                $display("FAIL rnd_filt[%0d] got fv=%b filt=%0d exp fv=%b filt=%0d",
                         i, obs_fv, obs_f, last_exp.fv, last_exp.f);
            end
            checks++;
            if (obs_shot !== last_exp.shot || obs_pk !== 16'(last_exp.pk) ||
                obs_st !== 2'(last_exp.st) || obs_busy !== (last_exp.st != 0)) begin
                errors++;
                $display("FAIL rnd_fsm[%0d] got shot=%b peak=%0d st=%0d busy=%b exp shot=%b peak=%0d st=%0d",
                         i, obs_shot, obs_pk, obs_st, obs_busy, last_exp.shot, last_exp.pk, last_exp.st);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        x_valid = 1'b0;
        x_raw   = '0;
        model_reset();
        test_reset();
        test_filter();
        test_valid_shot();
        test_cooldown();
        test_timeout();
        test_reset_release();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got no completion exp finish within 5 ms");
        $fatal(1, "watchdog");
    end

endmodule
